// File: rtl/mem_store_buffer_if.sv
// Store-request and memory-write bundle for mem_store_buffer.
// The datapath/memory side uses master; the buffer uses slave.
interface mem_store_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic [1:0]            st_size;
    logic                  mem_wr_req;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [3:0]            mem_wr_be;
    logic                  mem_wr_ack;
    logic                  misalign_err;
    logic                  empty;
    logic [CW-1:0]         count;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_wr_ack,
        input  st_ready, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be,
               misalign_err, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_wr_ack,
        output st_ready, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_be,
               misalign_err, empty, count
    );
endinterface

// File: rtl/mem_store_buffer.sv
// Store buffer: lane-aligns SB/SH/SW stores, queues them in a small FIFO and
// drains them to the data memory write port with a req/ack handshake.
module mem_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic clk,
    input  logic rst,
    mem_store_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         rd_ptr, wr_ptr, rd_next;
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [3:0]            be_mem   [DEPTH];

    logic [1:0]            off;
    logic                  mis;
    logic [ADDR_WIDTH-1:0] al_addr;
    logic [DATA_WIDTH-1:0] al_data;
    logic [3:0]            al_be;
    logic                  accept, push, pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [3:0]            head_be;

    assign off     = bus.st_addr[1:0];
    assign al_addr = {bus.st_addr[ADDR_WIDTH-1:2], 2'b00};
    assign accept  = bus.st_valid && bus.st_ready;
    assign push    = accept && !mis;
    assign pop     = (state_q == REQ) && bus.mem_wr_ack;

    always_comb begin
        al_data = '0;
        al_be   = '0;
        mis     = 1'b0;
        case (bus.st_size)
            2'b00: begin
                al_data = {{(DATA_WIDTH-8){1'b0}}, bus.st_data[7:0]} << {off, 3'b000};
                al_be   = 4'b0001 << off;
            end
            2'b01: begin
                al_data = {{(DATA_WIDTH-16){1'b0}}, bus.st_data[15:0]} << {off[1], 4'b0000};
                al_be   = 4'b0011 << off;
                mis     = off[0];
            end
            2'b10: begin
                al_data = bus.st_data;
                al_be   = 4'b1111;
                mis     = (off != 2'b00);
            end
            default: mis = 1'b1;
        endcase
    end

    // Next head: the entry behind a popped head, or the incoming store when
    // the buffer is (or is about to become) empty on this edge.
    always_comb begin
        rd_next = pop ? rd_ptr + PW'(1) : rd_ptr;
        if (cnt_q == '0 || (cnt_q == CW'(1) && pop)) begin
            head_addr = al_addr;
            head_data = al_data;
            head_be   = al_be;
        end else begin
            head_addr = addr_mem[rd_next];
            head_data = data_mem[rd_next];
            head_be   = be_mem[rd_next];
        end
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (cnt_d != '0) ? REQ : IDLE;
            REQ:     state_d = (cnt_d != '0) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= al_addr;
            data_mem[wr_ptr] <= al_data;
            be_mem[wr_ptr]   <= al_be;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            bus.misalign_err <= 1'b0;
            bus.mem_wr_addr  <= '0;
            bus.mem_wr_data  <= '0;
            bus.mem_wr_be    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bus.misalign_err <= accept && mis;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (state_d == REQ) begin
                bus.mem_wr_addr <= head_addr;
                bus.mem_wr_data <= head_data;
                bus.mem_wr_be   <= head_be;
            end else begin
                bus.mem_wr_addr <= '0;
                bus.mem_wr_data <= '0;
                bus.mem_wr_be   <= '0;
            end
        end
    end

    assign bus.mem_wr_req = (state_q == REQ);
    assign bus.count      = cnt_q;
    assign bus.empty      = (cnt_q == '0);
    assign bus.st_ready   = rst && (cnt_q < CW'(DEPTH));
endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: directed scenarios then random stores,
// with a byte-lane reference model and a negedge monitor.
`timescale 1ns/1ps
module tb_mem_store_buffer;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ack_mode = 2;  // 0 random, 1 held high, 2 held low
    bit   err_flag = 1'b0;
    wr_t  sbq[$];

    mem_store_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

    mem_store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: place the store's bytes lane by lane starting at the byte offset.
    task automatic model(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                         output wr_t w, output bit mis);
        int nb;
        int o;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        o = int'(addr[1:0]);
        mis = (size == 2'd3) || ((o % nb) != 0);
        w.a = addr & ~32'h3;
        w.d = '0;
        w.be = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= o && i < o + nb) begin
                w.be[i] = 1'b1;
                w.d[8*i +: 8] = data[8*(i-o) +: 8];
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (ack_mode)
            1: bus.mem_wr_ack = 1'b1;
            2: bus.mem_wr_ack = 1'b0;
            default: bus.mem_wr_ack = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            check("st_ready", 64'(bus.st_ready), 64'(sbq.size() < DEPTH));
            check("count", 64'(bus.count), 64'(sbq.size()));
            check("empty", 64'(bus.empty), 64'(sbq.size() == 0));
            check("mem_wr_req", 64'(bus.mem_wr_req), 64'(sbq.size() != 0));
            if (err_flag || bus.misalign_err)
                check("misalign_err", 64'(bus.misalign_err), 64'(err_flag));
            err_flag = 1'b0;
            if (bus.mem_wr_req && sbq.size() != 0) begin
                check("mem_wr_addr", 64'(bus.mem_wr_addr), 64'(sbq[0].a));
                check("mem_wr_data", 64'(bus.mem_wr_data), 64'(sbq[0].d));
                check("mem_wr_be", 64'(bus.mem_wr_be), 64'(sbq[0].be));
                if (bus.mem_wr_ack) void'(sbq.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        wr_t w;
        bit  mis;
        bit  done;
        model(addr, data, size, w, mis);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            done = bus.st_ready;
            @(posedge clk);
            if (done) begin
                if (mis) err_flag = 1'b1;
                else sbq.push_back(w);
            end
            #1;
        end
        if (!done) check("st_ready_timeout", 64'(done), 64'd1);
        bus.st_valid = 1'b0;
    endtask

    task automatic drain();
        ack_mode = 1;
        for (int i = 0; i < 64 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(sbq.size()), 64'd0);
        idle(1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr = '0;
        bus.st_data = '0;
        bus.st_size = '0;
        bus.mem_wr_ack = 1'b0;
        #3;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_req", 64'(bus.mem_wr_req), 64'd0);
        check("rst_addr", 64'(bus.mem_wr_addr), 64'd0);
        check("rst_data", 64'(bus.mem_wr_data), 64'd0);
        check("rst_be", 64'(bus.mem_wr_be), 64'd0);
        check("rst_err", 64'(bus.misalign_err), 64'd0);
        check("rst_ready", 64'(bus.st_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        ack_mode = 2;
        send(32'h100, 32'hDEADBEEF, 2'b10);
        idle(3);
        drain();

        send(32'h203, 32'h000000A5, 2'b00);
        send(32'h202, 32'h00001234, 2'b01);
        drain();

        send(32'h101, 32'h0000BEEF, 2'b01);
        send(32'h102, 32'h11223344, 2'b10);
        send(32'h104, 32'h55667788, 2'b11);
        idle(3);

        ack_mode = 2;
        send(32'h300, 32'hA0A0A0A0, 2'b10);
        send(32'h304, 32'hB1B1B1B1, 2'b10);
        fork
            send(32'h308, 32'hC2C2C2C2, 2'b10);
            begin
                idle(3);
                ack_mode = 1;
            end
        join
        drain();

        ack_mode = 2;
        send(32'h400, 32'h0000_00D1, 2'b00);
        ack_mode = 1;
        send(32'h406, 32'h0000_E2E2, 2'b01);
        ack_mode = 2;
        idle(2);
        drain();

        ack_mode = 2;
        send(32'h500, 32'h12345678, 2'b10);
        send(32'h504, 32'h9ABCDEF0, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check("async_req", 64'(bus.mem_wr_req), 64'd0);
        check("async_count", 64'(bus.count), 64'd0);
        check("async_empty", 64'(bus.empty), 64'd1);
        sbq.delete();
        err_flag = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ack_mode = 0;
        idle(4);

        for (int n = 0; n < 300; n++) begin
            send($urandom, $urandom, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_store_buffer.md
# mem_store_buffer

Store-side counterpart to the memory data register: accepts store requests from the multicycle datapath, aligns store data onto byte lanes for SB/SH/SW, and buffers them in a small FIFO. It drives the data memory write port with a registered request/acknowledge handshake. It sits between the datapath's store stage and the data memory write interface, and absorbs memory write stalls so the datapath can continue.

## Interface
- DATA_WIDTH, 32, store data and memory data width (fixed at 32; 4 byte lanes)
- ADDR_WIDTH, 32, byte address width
- DEPTH, 2, buffer entries (power of two, ≥2)

- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept; transfer occurs when st_valid && st_ready at posedge
- st_addr  in  ADDR_WIDTH  byte address
- st_data  in  DATA_WIDTH  store data, right-justified
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_wr_req  out  1  write request to memory (registered)
- mem_wr_addr  out  ADDR_WIDTH  word-aligned address {st_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wr_data  out  DATA_WIDTH  lane-aligned data
- mem_wr_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i])
- mem_wr_ack  in  1  memory accepted current write
- misalign_err  out  1  one-cycle pulse: rejected store
- empty  out  1  no buffered or in-flight stores
- count  out  $clog2(DEPTH)+1  resident entries, including the head being written

## Operation
- st_ready = (count < DEPTH) while rst is high; 0 while rst is low.
- Lane alignment at enqueue, with o = st_addr[1:0]:
  - Byte: data = st_data[7:0] << 8·o; be = 4'b0001 << o.
  - Half: data = st_data[15:0] << 16·o[1]; be = 4'b0011 << o.
  - Word: data = st_data; be = 4'b1111.
  - Unused lanes are driven 0.
- Misaligned stores are consumed (handshake completes) but not enqueued; misalign_err pulses high for the cycle after the accepting edge. A store is misaligned when any of these holds:
  - Half with o[0]=1.
  - Word with o≠0.
  - st_size=11.
- FSM:
  - IDLE: mem_wr_req=0. If count>0 at a posedge, go to REQ.
  - REQ: mem_wr_req=1; mem_wr_addr/data/be show the FIFO head and hold stable until ack.
  - On posedge with mem_wr_ack=1 in REQ: pop the head. Stay in REQ if another entry remains (next head presented the following cycle, back-to-back); otherwise go to IDLE.
- mem_wr_ack is ignored in IDLE.
- Push and pop on the same edge: count unchanged, both take effect.
- When full, st_ready is 0 for the whole cycle even if ack arrives; it re-asserts the cycle after the pop.
- FIFO pointers wrap modulo DEPTH.
- empty = (count==0).

## Timing
- Reset values: count=0, empty=1, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_be=0, misalign_err=0, FSM=IDLE, pointers=0.
- rst low mid-transaction: mem_wr_req drops immediately; all buffered stores are discarded.
- Latency, store accepted at edge N into an empty buffer: mem_wr_req high from edge N+1. Minimum cycles from acceptance to memory acceptance = 2, with ack in the first REQ cycle.
- Throughput: one store per cycle when ack is held high.
- Outputs other than st_ready are registered.

## Test plan
- Reset, then SW addr 0x100 data 0xDEADBEEF -> one cycle later: req=1, addr 0x100, data 0xDEADBEEF, be 1111. Hold ack low for 3 cycles: outputs stable. Ack -> empty=1 the next cycle.
- SB addr 0x203 data 0x000000A5 -> addr 0x200, data 0xA5000000, be 1000. SH addr 0x202 data 0x1234 -> data 0x12340000, be 1100.
- SH addr 0x101, SW addr 0x102, and st_size=11 -> each accepted (st_ready=1), misalign_err pulses once per store, count stays 0, mem_wr_req never asserts.
- Fill both entries with ack low -> st_ready=0, count=2. A third st_valid is held until the cycle after the first ack. Writes appear in order, back-to-back with ack held high.
- Simultaneous push and ack at count=1 -> count stays 1, req stays high, next head is the newly pushed store.
- rst low while req=1 with count=2 -> req=0, count=0, empty=1 asynchronously. After release, no stale write is issued.
